mul_div_unit: RTL
=================

# mul_div_unit

Sequential signed 32-bit multiply/divide engine feeding the Z_high / Z_low inputs of the 32:1 bus multiplexer. It takes operand A from the Y register and operand B from the bus, and iterates one bit per clock. It writes a 64-bit result: product, or remainder:quotient. The control unit then gates that result onto the bus and from there into HI/LO.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH.
- clock  in  1  system clock, rising-edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  begin an operation; sampled only in IDLE.
- op  in  1  0 = MUL, 1 = DIV; latched with start.
- Y_in  in  32  operand A (multiplicand / dividend), latched with start.
- bus_in  in  32  operand B (multiplier / divisor), latched with start.
- busy  out  1  high in MUL, DIV, FIX states.
- done  out  1  one-cycle pulse; result valid from this cycle.
- div_by_zero  out  1  set with done for DIV with B = 0; cleared on next accepted start.
- Z_high  out  32  product[63:32] or remainder.
- Z_low  out  32  product[31:0] or quotient.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - start & op=0 → MUL.
  - start & op=1 & B≠0 → DIV.
  - start & op=1 & B=0 → DONE, with Z_high=A, Z_low=32'hFFFFFFFF, div_by_zero=1.
- MUL: radix-2 Booth on two's-complement operands.
  - Accumulator is 65 bits ({P_hi, P_lo, q-1}).
  - Each step: add/subtract A by the {q0,q-1} pair, then arithmetic shift right 1.
  - 32 steps, then → DONE; the full 64-bit signed product is written to Z.
- DIV: restoring division on magnitudes |A|, |B|.
  - 32 steps, then → FIX.
  - FIX negates the quotient if sign(A)≠sign(B) and negates the remainder if A<0.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - FIX → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE unconditionally. start during DONE is ignored.
- start while busy is ignored. Operands are not re-sampled mid-operation.
- Z_high/Z_low change only on entry to DONE and hold until the next result or clear.
- Overflow case 32'h80000000 / 32'hFFFFFFFF: quotient 32'h80000000, remainder 0, no flag.
- A 6-bit iteration counter counts 0..31; it is not reset by start while busy.

## Timing
- Reset (clear=0, asynchronous): state=IDLE, busy=0, done=0, div_by_zero=0, Z_high=0, Z_low=0, counter=0.
- Cycle 0 is the edge where start is accepted.
- MUL: busy high in cycles 1–32; done and result in cycle 33.
- DIV (B≠0): busy high in cycles 1–33 (32 iterations plus FIX); done in cycle 34.
- DIV by zero: done in cycle 1, busy never asserted.
- Next start is accepted at the earliest in the cycle after done (back in IDLE).
- clear mid-operation aborts immediately; the partial result is discarded and all outputs go to reset values.

## Structure
- Package mul_div_pkg holds:
  - state enum (IDLE, MUL, DIV, FIX, DONE);
  - op encoding constants OP_MUL=1'b0, OP_DIV=1'b1;
  - WIDTH;
  - latency constants MUL_LAT=33, DIV_LAT=34.
- One combinational sub-module, booth_step, computes one Booth add/shift on the 65-bit accumulator.
- The division step stays inline in the top module.

## Test plan
- MUL 32'd7 × 32'hFFFFFFFD (−3) → Z_high=FFFFFFFF, Z_low=FFFFFFEB; done exactly at cycle 33; busy high cycles 1–32.
- MUL 32'h80000000 × 32'h80000000 → Z_high=40000000, Z_low=00000000.
- DIV 32'hFFFFFFF9 (−7) / 32'd2 → Z_low=FFFFFFFD, Z_high=FFFFFFFF; done at cycle 34.
- DIV 32'd5 / 0 → div_by_zero=1, Z_high=00000005, Z_low=FFFFFFFF; done at cycle 1; busy stays 0.
- DIV 32'h80000000 / 32'hFFFFFFFF → Z_low=80000000, Z_high=00000000, div_by_zero=0.
- Start MUL 3×4, pulse start with new operands at cycle 5: it is ignored and the result is 12. Start another MUL and drive clear=0 at cycle 10: busy=0, Z=0, state IDLE immediately; no done pulse follows.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared types and constants for the sequential signed multiply/divide engine.
package mul_div_pkg;
    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 33;
    localparam int DIV_LAT = 34;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction
endpackage

// File: rtl/mul_div_unit_booth_step.sv
// One radix-2 Booth add/subtract plus arithmetic shift on {P_hi, P_lo, q-1}.
module booth_step
    import mul_div_pkg::*;
(
    input  logic [2*WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0]   a_i,
    output logic [2*WIDTH:0]   acc_o
);
    logic [WIDTH:0] hi_ext;
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] sum;

    // The add is one bit wider so the most negative multiplicand cannot
    // corrupt the sign that the shift brings in.
    assign hi_ext = {acc_i[2*WIDTH], acc_i[2*WIDTH:WIDTH+1]};
    assign a_ext  = {a_i[WIDTH-1], a_i};

    always_comb begin
        case (acc_i[1:0])
            2'b01:   sum = hi_ext + a_ext;
            2'b10:   sum = hi_ext - a_ext;
            default: sum = hi_ext;
        endcase
    end

    assign acc_o = {sum, acc_i[WIDTH:1]};
endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed MUL (Booth) / DIV (restoring on magnitudes) feeding Z_high/Z_low.
module mul_div_unit
    import mul_div_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] Y_in,
    input  logic [WIDTH-1:0] bus_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] Z_high,
    output logic [WIDTH-1:0] Z_low
);
    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic               qneg_q, qneg_d, rneg_q, rneg_d;
    logic [WIDTH-1:0]   zh_q, zh_d, zl_q, zl_d;
    logic               dbz_q, dbz_d;

    logic [2*WIDTH:0]   booth_acc;
    logic [WIDTH-1:0]   rem, quo, rem_nxt, quo_nxt;
    logic [WIDTH:0]     shifted;
    logic               ge;

    booth_step u_booth (
        .acc_i (acc_q),
        .a_i   (opa_q),
        .acc_o (booth_acc)
    );

    // DIV packs remainder:quotient into the low 64 bits of the accumulator.
    assign rem     = acc_q[2*WIDTH-1:WIDTH];
    assign quo     = acc_q[WIDTH-1:0];
    assign shifted = {rem, quo[WIDTH-1]};
    assign ge      = shifted >= {1'b0, opa_q};
    assign rem_nxt = ge ? (shifted[WIDTH-1:0] - opa_q) : shifted[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zh_d    = zh_q;
        zl_d    = zl_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (start) begin
                cnt_d = '0;
                dbz_d = 1'b0;
                if (op == OP_MUL) begin
                    acc_d   = {{WIDTH{1'b0}}, bus_in, 1'b0};
                    opa_d   = Y_in;
                    state_d = MUL;
                end else if (bus_in == '0) begin
                    zh_d    = Y_in;
                    zl_d    = '1;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    acc_d   = {{(WIDTH+1){1'b0}}, mag(Y_in)};
                    opa_d   = mag(bus_in);
                    qneg_d  = Y_in[WIDTH-1] ^ bus_in[WIDTH-1];
                    rneg_d  = Y_in[WIDTH-1];
                    state_d = DIV;
                end
            end
            MUL: begin
                acc_d = booth_acc;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    cnt_d   = '0;
                    zh_d    = booth_acc[2*WIDTH:WIDTH+1];
                    zl_d    = booth_acc[WIDTH:1];
                    state_d = DONE;
                end
            end
            DIV: begin
                acc_d = {1'b0, rem_nxt, quo_nxt};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                zl_d    = qneg_q ? (~quo + 1'b1) : quo;
                zh_d    = rneg_q ? (~rem + 1'b1) : rem;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zh_q    <= '0;
            zl_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zh_q    <= zh_d;
            zl_q    <= zl_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign div_by_zero = dbz_q;
    assign Z_high      = zh_q;
    assign Z_low       = zl_q;
endmodule
